// File: rtl/enigma_ctrl.sv
// ============================================================================
// enigma_ctrl : Enigma command sequencer, rotor stepping and datapath handshake
// Rev 1.0
// ============================================================================
`default_nettype none

module enigma_ctrl #(
   parameter int NOTCH0  = 16,
   parameter int NOTCH1  = 4,
   parameter int TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [2:0]  cmd_op,
   input  logic [4:0]  cmd_data,
   output logic        dp_start,
   output logic [4:0]  dp_char,
   output logic [14:0] dp_pos,
   input  logic        dp_done,
   input  logic [4:0]  dp_result,
   output logic        out_valid,
   output logic [4:0]  out_char,
   output logic        out_err,
   output logic        busy
);

   localparam logic [2:0] OP_SET0 = 3'd1;
   localparam logic [2:0] OP_SET1 = 3'd2;
   localparam logic [2:0] OP_SET2 = 3'd3;
   localparam logic [2:0] OP_ENC  = 3'd4;
   localparam logic [2:0] OP_CLR  = 3'd5;

   localparam logic [4:0] C_NOTCH0   = 5'(NOTCH0);
   localparam logic [4:0] C_NOTCH1   = 5'(NOTCH1);
   localparam logic [7:0] C_TMO_LAST = 8'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_STEP  = 3'd1,
      S_START = 3'd2,
      S_WAIT  = 3'd3,
      S_OUT   = 3'd4
   } state_t;

   state_t     state, state_nxt;
   logic [4:0] pos0, pos1, pos2;
   logic [7:0] tmo_cnt;

   function automatic logic [4:0] wrap26(input logic [4:0] d);
      return (d >= 5'd26) ? d - 5'd26 : d;
   endfunction

   function automatic logic [4:0] inc26(input logic [4:0] p);
      return (p == 5'd25) ? 5'd0 : p + 5'd1;
   endfunction

   assign dp_pos = {pos2, pos1, pos0};
   assign busy   = (state != S_IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      cmd_ready = 1'b0;
      dp_start  = 1'b0;
      out_valid = 1'b0;
      case (state)
         S_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid && cmd_op == OP_ENC)
               state_nxt = (cmd_data < 5'd26) ? S_STEP : S_OUT;
         end
         S_STEP:  state_nxt = S_START;
         S_START: begin
            dp_start  = 1'b1;
            state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (dp_done || tmo_cnt == C_TMO_LAST) state_nxt = S_OUT;
         end
         S_OUT: begin
            out_valid = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pos0     <= '0;
         pos1     <= '0;
         pos2     <= '0;
         dp_char  <= '0;
         out_char <= '0;
         out_err  <= 1'b0;
         tmo_cnt  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (cmd_valid) begin
                  case (cmd_op)
                     OP_SET0: pos0 <= wrap26(cmd_data);
                     OP_SET1: pos1 <= wrap26(cmd_data);
                     OP_SET2: pos2 <= wrap26(cmd_data);
                     OP_CLR: begin
                        pos0 <= '0;
                        pos1 <= '0;
                        pos2 <= '0;
                     end
                     OP_ENC: begin
                        if (cmd_data < 5'd26) begin
                           dp_char <= cmd_data;
                        end else begin
                           out_char <= '0;
                           out_err  <= 1'b1;
                        end
                     end
                     default: ;
                  endcase
               end
            end
            S_STEP: begin
               // Notch tests use pre-step values; pos1 at its notch double-steps.
               pos0 <= inc26(pos0);
               if (pos0 == C_NOTCH0 || pos1 == C_NOTCH1) pos1 <= inc26(pos1);
               if (pos1 == C_NOTCH1) pos2 <= inc26(pos2);
            end
            S_START: tmo_cnt <= '0;
            S_WAIT: begin
               if (dp_done) begin
                  out_char <= dp_result;
                  out_err  <= 1'b0;
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
                  if (tmo_cnt == C_TMO_LAST) begin
                     out_char <= '0;
                     out_err  <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_enigma_ctrl.sv
// ============================================================================
// tb_enigma_ctrl : directed self-checking bench for enigma_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_enigma_ctrl;

   localparam int TIMEOUT = 15;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [2:0]  cmd_op = 3'd0;
   logic [4:0]  cmd_data = 5'd0;
   logic        dp_start;
   logic [4:0]  dp_char;
   logic [14:0] dp_pos;
   logic        dp_done = 1'b0;
   logic [4:0]  dp_result = 5'd0;
   logic        out_valid;
   logic [4:0]  out_char;
   logic        out_err;
   logic        busy;

   int checks = 0;
   int errors = 0;

   enigma_ctrl #(.NOTCH0(16), .NOTCH1(4), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
      .dp_start(dp_start), .dp_char(dp_char), .dp_pos(dp_pos),
      .dp_done(dp_done), .dp_result(dp_result),
      .out_valid(out_valid), .out_char(out_char), .out_err(out_err), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] pk(input int p2, input int p1, input int p0);
      logic [14:0] v;
      v = {5'(p2), 5'(p1), 5'(p0)};
      return 32'(v);
   endfunction

   task automatic send(input logic [2:0] op, input logic [4:0] data);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = data;
      check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
      tick;
      cmd_valid = 1'b0;
      cmd_op    = 3'd0;
   endtask

   // Valid ENCRYPT, dp_done given in the first WAIT cycle.
   task automatic encrypt(input string tag, input logic [4:0] ch,
                          input logic [31:0] exp_pos, input logic [4:0] res);
      send(3'd4, ch);
      check({tag, "_c1_start"}, 32'(dp_start), 32'd0);
      check({tag, "_c1_busy"}, 32'(busy), 32'd1);
      tick;
      check({tag, "_c2_start"}, 32'(dp_start), 32'd1);
      check({tag, "_c2_pos"}, 32'(dp_pos), exp_pos);
      check({tag, "_c2_char"}, 32'(dp_char), 32'(ch));
      tick;
      dp_done   = 1'b1;
      dp_result = res;
      check({tag, "_c3_valid"}, 32'(out_valid), 32'd0);
      tick;
      dp_done = 1'b0;
      check({tag, "_c4_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_c4_char"}, 32'(out_char), 32'(res));
      check({tag, "_c4_err"}, 32'(out_err), 32'd0);
      tick;
      check({tag, "_c5_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_c5_ready"}, 32'(cmd_ready), 32'd1);
      check({tag, "_c5_char_held"}, 32'(out_char), 32'(res));
   endtask

   initial begin
      int  n;
      bool_t_dummy: begin end
      rst = 1'b1;
      tick;
      tick;
      check("rst_pos", 32'(dp_pos), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_outchar", 32'(out_char), 32'd0);
      check("rst_err", 32'(out_err), 32'd0);
      check("rst_start", 32'(dp_start), 32'd0);
      #2 rst = 1'b0;
      tick;
      check("idle_ready", 32'(cmd_ready), 32'd1);

      encrypt("enc0", 5'd0, pk(0, 0, 1), 5'd7);

      send(3'd1, 5'd16);
      send(3'd2, 5'd3);
      send(3'd3, 5'd0);
      check("set_pos_a", 32'(dp_pos), pk(0, 3, 16));
      encrypt("turn", 5'd10, pk(0, 4, 17), 5'd21);

      send(3'd1, 5'd5);
      send(3'd2, 5'd4);
      send(3'd3, 5'd0);
      encrypt("dbl", 5'd25, pk(1, 5, 6), 5'd2);

      send(3'd1, 5'd25);
      send(3'd2, 5'd25);
      send(3'd3, 5'd25);
      encrypt("wrap", 5'd13, pk(25, 25, 0), 5'd19);

      send(3'd6, 5'd3);
      send(3'd0, 5'd3);
      check("nop_pos", 32'(dp_pos), pk(25, 25, 0));

      send(3'd2, 5'd30);
      check("set_wrap", 32'(dp_pos), pk(25, 4, 0));

      // Invalid letter: straight to OUT with error, no launch.
      send(3'd4, 5'd27);
      check("bad_valid", 32'(out_valid), 32'd1);
      check("bad_err", 32'(out_err), 32'd1);
      check("bad_char", 32'(out_char), 32'd0);
      check("bad_start", 32'(dp_start), 32'd0);
      check("bad_pos", 32'(dp_pos), pk(25, 4, 0));
      tick;
      check("bad_idle", 32'(cmd_ready), 32'd1);

      // Timeout, with a SET_POS0 held pending throughout busy.
      send(3'd4, 5'd8);
      cmd_valid = 1'b1;
      cmd_op    = 3'd1;
      cmd_data  = 5'd9;
      tick;
      check("to_start", 32'(dp_start), 32'd1);
      check("to_pos", 32'(dp_pos), pk(0, 5, 1));
      n = 0;
      while (n < 40 && out_valid !== 1'b1) begin
         tick;
         n++;
         if (out_valid !== 1'b1 && cmd_ready !== 1'b0)
            check("to_ready_busy", 32'(cmd_ready), 32'd0);
      end
      check("to_cycles", 32'(n), 32'(TIMEOUT + 1));
      check("to_err", 32'(out_err), 32'd1);
      check("to_char", 32'(out_char), 32'd0);
      check("to_pos_held", 32'(dp_pos), pk(0, 5, 1));
      tick;
      check("to_ready_back", 32'(cmd_ready), 32'd1);
      tick;
      cmd_valid = 1'b0;
      cmd_op    = 3'd0;
      check("to_set_after", 32'(dp_pos), pk(0, 5, 9));

      // Reset while waiting on the datapath.
      send(3'd4, 5'd3);
      tick;
      tick;
      check("rw_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      check("rw_pos", 32'(dp_pos), 32'd0);
      check("rw_busy0", 32'(busy), 32'd0);
      check("rw_char", 32'(dp_char), 32'd0);
      check("rw_err", 32'(out_err), 32'd0);
      tick;
      rst       = 1'b0;
      dp_done   = 1'b1;
      dp_result = 5'd9;
      n = 0;
      for (int i = 0; i < 4; i++) begin
         tick;
         if (out_valid === 1'b1 || busy === 1'b1) n++;
      end
      check("rw_done_ignored", 32'(n), 32'd0);
      dp_done = 1'b0;
      encrypt("post_rst", 5'd0, pk(0, 0, 1), 5'd12);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

endmodule

`default_nettype wire
